// File: rtl/hit_count_mem.sv
// Per-row hit counter with HIM address allocation, built as a read-modify-write
// pipeline over a simple dual-port RAM; a short write history forwards commits the RAM read missed.
//
//  state | meaning
//  CLEAR | sweep zeros into every row, one per cycle; allocator reset
//  RUN   | accept one hit or query per cycle
//  DRAIN | accept nothing, wait for in-flight requests to commit
module hit_count_mem #(
    parameter int ROW_BITS     = 10,
    parameter int HITN_BITS    = 3,
    parameter int ADDR_BITS    = 8,
    parameter int INFO_BITS    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hit_valid,
    input  logic [ROW_BITS-1:0]  hit_row,
    input  logic [INFO_BITS-1:0] hit_info,
    output logic                 hit_ready,
    input  logic                 query_valid,
    input  logic [ROW_BITS-1:0]  query_row,
    output logic                 query_ready,
    input  logic                 clear_req,
    output logic                 out_valid,
    output logic [ROW_BITS-1:0]  out_row,
    output logic [INFO_BITS-1:0] out_info,
    output logic [HITN_BITS-1:0] out_old_n,
    output logic [HITN_BITS-1:0] out_new_n,
    output logic [ADDR_BITS-1:0] out_him_addr,
    output logic                 out_drop,
    output logic                 q_done,
    output logic [ROW_BITS-1:0]  q_row,
    output logic [HITN_BITS-1:0] q_n,
    output logic [ADDR_BITS-1:0] q_addr,
    output logic                 alloc_full,
    output logic [15:0]          drop_cnt,
    output logic                 busy
);
    localparam int DEPTH     = 1 << ROW_BITS;
    localparam int WORD_BITS = ADDR_BITS + HITN_BITS;
    localparam int RL        = READ_LATENCY;
    localparam logic [HITN_BITS-1:0] MAX_N = '1;
    localparam logic [HITN_BITS-1:0] ONE_N = HITN_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ONE_A = ADDR_BITS'(1);
    localparam logic [ROW_BITS-1:0]  ONE_R = ROW_BITS'(1);

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} stateT;

    stateT                 state;
    logic [ROW_BITS-1:0]   clrRow;
    logic [ADDR_BITS-1:0]  nextAddr;
    logic [WORD_BITS-1:0]  mem [DEPTH];
    logic [WORD_BITS-1:0]  rdPipe [RL];
    logic                  pValid [RL];
    logic                  pHit [RL];
    logic [ROW_BITS-1:0]   pRow [RL];
    logic [INFO_BITS-1:0]  pInfo [RL];
    logic                  hValid [RL];
    logic [ROW_BITS-1:0]   hRow [RL];
    logic [WORD_BITS-1:0]  hWord [RL];

    logic                  hitAcc, queryAcc, pipeEmpty;
    logic [ROW_BITS-1:0]   readRow, cRow;
    logic                  cValid, cHit;
    logic [WORD_BITS-1:0]  curWord, wrWord, memData;
    logic [HITN_BITS-1:0]  curN, newN;
    logic [ADDR_BITS-1:0]  curAddr, himAddr;
    logic                  wrEn, drop, allocate, memWe;
    logic [ROW_BITS-1:0]   memRow;

    assign hit_ready   = (state == RUN);
    assign query_ready = (state == RUN) && !hit_valid;
    assign busy        = (state != RUN);
    assign hitAcc      = hit_valid && hit_ready;
    assign queryAcc    = query_valid && query_ready;
    assign readRow     = hitAcc ? hit_row : query_row;

    assign cValid  = pValid[RL-1];
    assign cHit    = pHit[RL-1];
    assign cRow    = pRow[RL-1];
    assign curN    = curWord[HITN_BITS-1:0];
    assign curAddr = curWord[WORD_BITS-1:HITN_BITS];

    always_comb begin
        pipeEmpty = 1'b1;
        for (int i = 0; i < RL; i++)
            if (pValid[i]) pipeEmpty = 1'b0;
    end

    // Walk oldest to youngest so the most recent matching commit wins.
    always_comb begin
        curWord = rdPipe[RL-1];
        for (int i = RL-1; i >= 0; i--)
            if (hValid[i] && hRow[i] == cRow) curWord = hWord[i];
    end

    always_comb begin
        wrEn     = 1'b0;
        wrWord   = curWord;
        drop     = 1'b0;
        newN     = curN;
        himAddr  = (curN == '0) ? '0 : curAddr;
        allocate = 1'b0;
        if (cValid && cHit) begin
            if (curN == '0) begin
                if (alloc_full) begin
                    drop = 1'b1;
                end else begin
                    wrEn     = 1'b1;
                    wrWord   = {nextAddr, ONE_N};
                    newN     = ONE_N;
                    himAddr  = nextAddr;
                    allocate = 1'b1;
                end
            end else if (curN == MAX_N) begin
                drop = 1'b1;
            end else begin
                wrEn   = 1'b1;
                newN   = curN + ONE_N;
                wrWord = {curAddr, newN};
            end
        end
    end

    assign memWe   = (state == CLEAR) || wrEn;
    assign memRow  = (state == CLEAR) ? clrRow : cRow;
    assign memData = (state == CLEAR) ? '0 : wrWord;

    always_ff @(posedge clk) begin
        if (memWe) mem[memRow] <= memData;
        rdPipe[0] <= mem[readRow];
        for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clrRow       <= '0;
            nextAddr     <= '0;
            alloc_full   <= 1'b0;
            drop_cnt     <= '0;
            out_valid    <= 1'b0;
            out_row      <= '0;
            out_info     <= '0;
            out_old_n    <= '0;
            out_new_n    <= '0;
            out_him_addr <= '0;
            out_drop     <= 1'b0;
            q_done       <= 1'b0;
            q_row        <= '0;
            q_n          <= '0;
            q_addr       <= '0;
            for (int i = 0; i < RL; i++) begin
                pValid[i] <= 1'b0;
                pHit[i]   <= 1'b0;
                pRow[i]   <= '0;
                pInfo[i]  <= '0;
                hValid[i] <= 1'b0;
                hRow[i]   <= '0;
                hWord[i]  <= '0;
            end
        end else begin
            pValid[0] <= hitAcc || queryAcc;
            pHit[0]   <= hitAcc;
            pRow[0]   <= readRow;
            pInfo[0]  <= hit_info;
            hValid[0] <= wrEn;
            hRow[0]   <= cRow;
            hWord[0]  <= wrWord;
            for (int i = 1; i < RL; i++) begin
                pValid[i] <= pValid[i-1];
                pHit[i]   <= pHit[i-1];
                pRow[i]   <= pRow[i-1];
                pInfo[i]  <= pInfo[i-1];
                hValid[i] <= hValid[i-1];
                hRow[i]   <= hRow[i-1];
                hWord[i]  <= hWord[i-1];
            end

            out_valid <= cValid && cHit;
            q_done    <= cValid && !cHit;
            if (cValid && cHit) begin
                out_row      <= cRow;
                out_info     <= pInfo[RL-1];
                out_old_n    <= curN;
                out_new_n    <= newN;
                out_him_addr <= himAddr;
                out_drop     <= drop;
            end
            if (cValid && !cHit) begin
                q_row  <= cRow;
                q_n    <= curN;
                q_addr <= curAddr;
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (allocate) begin
                nextAddr <= nextAddr + ONE_A;
                if (nextAddr == '1) alloc_full <= 1'b1;
            end

            case (state)
                CLEAR: begin
                    clrRow <= clrRow + ONE_R;
                    if (clrRow == '1) state <= RUN;
                end
                RUN: if (clear_req) state <= DRAIN;
                DRAIN: if (pipeEmpty) begin
                    state      <= CLEAR;
                    clrRow     <= '0;
                    nextAddr   <= '0;
                    alloc_full <= 1'b0;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
